// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
// Bundles the two requester handshakes, the returned read data and the
// SRAM pin group of the character-RAM arbiter.
//   slave  modport : the arbiter. It takes the requests and SRAM read data,
//                    and drives grants, completions, rd_data, SRAM pins and busy.
//   master modport : requesters plus SRAM model. This is the mirror image.
interface sram_port_arbiter_if;
    logic       host_req;
    logic       host_write;
    logic [9:0] host_address;
    logic [7:0] host_wr_data;
    logic       host_gnt;
    logic       host_done;

    logic       ca_req;
    logic       ca_write;
    logic [9:0] ca_address;
    logic [7:0] ca_wr_data;
    logic       ca_gnt;
    logic       ca_done;

    logic [7:0] rd_data;
    logic [7:0] sram_read_data;
    logic [9:0] sram_address;
    logic [7:0] sram_write_data;
    logic       sram_write_enable;
    logic       busy;

    modport slave (
        input  host_req, host_write, host_address, host_wr_data,
        input  ca_req, ca_write, ca_address, ca_wr_data,
        input  sram_read_data,
        output host_gnt, host_done, ca_gnt, ca_done,
        output rd_data, sram_address, sram_write_data, sram_write_enable, busy
    );

    modport master (
        output host_req, host_write, host_address, host_wr_data,
        output ca_req, ca_write, ca_address, ca_wr_data,
        output sram_read_data,
        input  host_gnt, host_done, ca_gnt, ca_done,
        input  rd_data, sram_address, sram_write_data, sram_write_enable, busy
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Shares the single-port 1K x 8 character SRAM between the UART host bus and
// the cellular-automaton update engine. Each access follows the sequence
// IDLE -> ACCESS -> RECOVER -> IDLE. At the sampling edge the winning request
// is registered. The write strobe is held for WR_CYCLES cycles, or the
// address is held for RD_CYCLES cycles before read data is captured. One
// recovery cycle follows, and the owner's done pulse is issued in it.
//
// Ports:
//   clk50_dup  system clock; all logic is on its rising edge
//   rst_n      asynchronous active-low reset; it aborts any access in flight
//   bus        sram_port_arbiter_if.slave, which carries:
//              host_* / ca_*   req, write, address, wr_data in; gnt, done out
//              rd_data         last captured read data
//              sram_*          registered SRAM address, write data and write strobe;
//                              sram_read_data comes in
//              busy            high whenever the arbiter is not idle
//
// Build option: SRAM_ARB_ROUND_ROBIN_EN
//   defined   - on a tie, the requester that did not own the previous access wins
//   undefined - on a tie, the host always wins (fixed priority)
module sram_port_arbiter #(
    parameter int WR_CYCLES = 1,
    parameter int RD_CYCLES = 2,
    parameter int CNT_W     = 4
) (
    input  logic               clk50_dup,
    input  logic               rst_n,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    localparam logic             OWNER_CA   = 1'b0;
    localparam logic             OWNER_HOST = 1'b1;
    localparam logic [CNT_W-1:0] WR_LAST    = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST    = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             owner_q;
    logic             last_owner_q;
    logic             write_q;
    logic [9:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rd_data_q;
    logic             we_q;
    logic             host_gnt_q;
    logic             ca_gnt_q;
    logic             host_done_q;
    logic             ca_done_q;
    logic             busy_q;

    logic             any_req_s;
    logic             win_host_s;
    logic             win_write_s;
    logic [9:0]       win_addr_s;
    logic [7:0]       win_wdata_s;
    logic [CNT_W-1:0] last_cnt_s;

`ifndef SRAM_ARB_ROUND_ROBIN_EN
    // Under fixed priority, last_owner is kept for observability only.
    logic             unused_last_owner_s;
    assign unused_last_owner_s = last_owner_q;
`endif

    // Choose the winner among the live requests, select its command, and pick the terminal count for the access in flight.
    always_comb begin
        any_req_s   = bus.host_req | bus.ca_req;
        win_host_s  = OWNER_CA;
        win_write_s = 1'b0;
        win_addr_s  = 10'd0;
        win_wdata_s = 8'd0;
        last_cnt_s  = RD_LAST;

        if (bus.host_req && bus.ca_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            win_host_s = (last_owner_q == OWNER_CA) ? OWNER_HOST : OWNER_CA;
`else
            win_host_s = OWNER_HOST;
`endif
        end else begin
            win_host_s = bus.host_req ? OWNER_HOST : OWNER_CA;
        end

        if (win_host_s == OWNER_HOST) begin
            win_write_s = bus.host_write;
            win_addr_s  = bus.host_address;
            win_wdata_s = bus.host_wr_data;
        end else begin
            win_write_s = bus.ca_write;
            win_addr_s  = bus.ca_address;
            win_wdata_s = bus.ca_wr_data;
        end

        if (write_q) begin
            last_cnt_s = WR_LAST;
        end else begin
            last_cnt_s = RD_LAST;
        end
    end

    // Access sequencer: all arbiter state and every output register.
    always_ff @(posedge clk50_dup or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            owner_q      <= OWNER_CA;
            last_owner_q <= OWNER_CA;
            write_q      <= 1'b0;
            addr_q       <= 10'd0;
            wdata_q      <= 8'd0;
            rd_data_q    <= 8'd0;
            we_q         <= 1'b0;
            host_gnt_q   <= 1'b0;
            ca_gnt_q     <= 1'b0;
            host_done_q  <= 1'b0;
            ca_done_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    host_done_q <= 1'b0;
                    ca_done_q   <= 1'b0;
                    if (any_req_s) begin
                        state_q    <= ST_ACCESS;
                        cnt_q      <= '0;
                        owner_q    <= win_host_s;
                        write_q    <= win_write_s;
                        addr_q     <= win_addr_s;
                        // A read leaves the previous write data on the pins.
                        wdata_q    <= win_write_s ? win_wdata_s : wdata_q;
                        we_q       <= win_write_s;
                        host_gnt_q <= (win_host_s == OWNER_HOST);
                        ca_gnt_q   <= (win_host_s == OWNER_CA);
                        busy_q     <= 1'b1;
                    end else begin
                        we_q       <= 1'b0;
                        host_gnt_q <= 1'b0;
                        ca_gnt_q   <= 1'b0;
                        busy_q     <= 1'b0;
                    end
                end
                ST_ACCESS: begin
                    host_gnt_q <= 1'b0;
                    ca_gnt_q   <= 1'b0;
                    cnt_q      <= cnt_q + CNT_ONE;
                    if (cnt_q == last_cnt_s) begin
                        state_q     <= ST_RECOVER;
                        we_q        <= 1'b0;
                        host_done_q <= (owner_q == OWNER_HOST);
                        ca_done_q   <= (owner_q == OWNER_CA);
                        rd_data_q   <= write_q ? rd_data_q : bus.sram_read_data;
                    end else begin
                        state_q <= ST_ACCESS;
                    end
                end
                ST_RECOVER: begin
                    state_q      <= ST_IDLE;
                    host_done_q  <= 1'b0;
                    ca_done_q    <= 1'b0;
                    last_owner_q <= owner_q;
                    busy_q       <= 1'b0;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    we_q        <= 1'b0;
                    host_gnt_q  <= 1'b0;
                    ca_gnt_q    <= 1'b0;
                    host_done_q <= 1'b0;
                    ca_done_q   <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.host_gnt          = host_gnt_q;
    assign bus.ca_gnt            = ca_gnt_q;
    assign bus.host_done         = host_done_q;
    assign bus.ca_done           = ca_done_q;
    assign bus.rd_data           = rd_data_q;
    assign bus.sram_address      = addr_q;
    assign bus.sram_write_data   = wdata_q;
    assign bus.sram_write_enable = we_q;
    assign bus.busy              = busy_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Bench for sram_port_arbiter. It uses directed scenarios and a randomized
// two-requester run. A 1K x 8 SRAM model sits on the pins. Expected values in
// the random run come from a transaction-timeline model: for each access it
// tracks the cycle offset since the grant.
module tb_sram_port_arbiter;
    localparam int TB_WR = 3;
    localparam int TB_RD = 2;

    logic clk;
    logic rst_n;
    logic mem_init;
    logic [7:0] mem [0:1023];
    int n_checks;
    int n_bad;

    sram_port_arbiter_if bus_if ();

    sram_port_arbiter #(.WR_CYCLES(TB_WR), .RD_CYCLES(TB_RD), .CNT_W(4)) dut (
        .clk50_dup (clk),
        .rst_n     (rst_n),
        .bus       (bus_if.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // SRAM model: a fixed preload pattern, then writes while the strobe is high.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= (i == 1023) ? 8'h3C : 8'(i * 37 + 11);
        end else if (bus_if.sram_write_enable) begin
            mem[bus_if.sram_address] <= bus_if.sram_write_data;
        end
    end
    assign bus_if.sram_read_data = mem[bus_if.sram_address];

    function automatic logic [5:0] flags();
        return {bus_if.host_gnt, bus_if.host_done, bus_if.ca_gnt, bus_if.ca_done,
                bus_if.busy, bus_if.sram_write_enable};
    endfunction

    task automatic idle_inputs();
        bus_if.host_req = 1'b0; bus_if.host_write = 1'b0;
        bus_if.host_address = 10'd0; bus_if.host_wr_data = 8'd0;
        bus_if.ca_req = 1'b0; bus_if.ca_write = 1'b0;
        bus_if.ca_address = 10'd0; bus_if.ca_wr_data = 8'd0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_init = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({flags(), bus_if.sram_address, bus_if.sram_write_data, bus_if.rd_data} !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h want=0", {flags(), bus_if.sram_address, bus_if.sram_write_data, bus_if.rd_data});
        end
        mem_init = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (flags() !== 6'b0) begin
            n_bad++; $display("FAIL reset_idle flags got=%b want=000000", flags());
        end
    endtask

    task automatic test_host_write();
        logic [5:0] exp_f;
        bus_if.host_req = 1'b1; bus_if.host_write = 1'b1;
        bus_if.host_address = 10'h155; bus_if.host_wr_data = 8'hA5;
        @(negedge clk);
        bus_if.host_req = 1'b0;
        for (int k = 0; k <= TB_WR + 1; k++) begin
            exp_f = {k == 0, k == TB_WR, 1'b0, 1'b0, k <= TB_WR, k < TB_WR};
            n_checks++;
            if (flags() !== exp_f) begin
                n_bad++; $display("FAIL host_write_flags k=%0d got=%b want=%b", k, flags(), exp_f);
            end
            n_checks++;
            if ({bus_if.sram_address, bus_if.sram_write_data} !== {10'h155, 8'hA5}) begin
                n_bad++; $display("FAIL host_write_pins k=%0d got=%h/%h want=155/a5", k, bus_if.sram_address, bus_if.sram_write_data);
            end
            @(negedge clk);
        end
        n_checks++;
        if (mem[10'h155] !== 8'hA5) begin
            n_bad++; $display("FAIL host_write_mem got=%h want=a5", mem[10'h155]);
        end
    endtask

    task automatic test_ca_read();
        logic [5:0] exp_f;
        bus_if.ca_req = 1'b1; bus_if.ca_write = 1'b0;
        bus_if.ca_address = 10'h3FF; bus_if.ca_wr_data = 8'hEE;
        @(negedge clk);
        bus_if.ca_req = 1'b0;
        for (int k = 0; k <= TB_RD + 1; k++) begin
            exp_f = {1'b0, 1'b0, k == 0, k == TB_RD, k <= TB_RD, 1'b0};
            n_checks++;
            if (flags() !== exp_f) begin
                n_bad++; $display("FAIL ca_read_flags k=%0d got=%b want=%b", k, flags(), exp_f);
            end
            n_checks++;
            if ({bus_if.sram_address, bus_if.sram_write_data} !== {10'h3FF, 8'hA5}) begin
                n_bad++; $display("FAIL ca_read_pins k=%0d got=%h/%h want=3ff/a5", k, bus_if.sram_address, bus_if.sram_write_data);
            end
            if (k >= TB_RD) begin
                n_checks++;
                if (bus_if.rd_data !== 8'h3C) begin
                    n_bad++; $display("FAIL ca_read_data k=%0d got=%h want=3c", k, bus_if.rd_data);
                end
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_if.rd_data !== 8'h3C) begin
            n_bad++; $display("FAIL ca_read_hold got=%h want=3c", bus_if.rd_data);
        end
    endtask

    task automatic test_tie();
        int n_gr;
        int last_cyc;
        logic exp_host;
        apply_reset();
        bus_if.host_req = 1'b1; bus_if.host_write = 1'b1; bus_if.host_address = 10'h001; bus_if.host_wr_data = 8'h11;
        bus_if.ca_req = 1'b1; bus_if.ca_write = 1'b1; bus_if.ca_address = 10'h002; bus_if.ca_wr_data = 8'h22;
        n_gr = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 200 && n_gr < 5; cyc++) begin
            @(negedge clk);
            n_checks++;
            if ((bus_if.host_gnt && bus_if.ca_gnt) || (bus_if.host_done && bus_if.ca_done)) begin
                n_bad++; $display("FAIL tie_overlap cyc=%0d flags=%b", cyc, flags());
            end
            if (bus_if.host_gnt || bus_if.ca_gnt) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                exp_host = (n_gr < 4) && (n_gr % 2 == 0);
`else
                exp_host = (n_gr < 4);
`endif
                n_checks++;
                if (bus_if.host_gnt !== exp_host) begin
                    n_bad++; $display("FAIL tie_order grant=%0d host_gnt got=%b want=%b", n_gr, bus_if.host_gnt, exp_host);
                end
                if (n_gr > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != TB_WR + 2) begin
                        n_bad++; $display("FAIL tie_spacing grant=%0d got=%0d want=%0d", n_gr, cyc - last_cyc, TB_WR + 2);
                    end
                end
                last_cyc = cyc;
                n_gr++;
                if (n_gr == 4) bus_if.host_req = 1'b0;
                if (n_gr == 5) bus_if.ca_req = 1'b0;
            end
        end
        n_checks++;
        if (n_gr != 5) begin
            n_bad++; $display("FAIL tie_timeout grants got=%0d want=5", n_gr);
        end
        idle_inputs();
        repeat (TB_WR + 3) @(negedge clk);
    endtask

    task automatic test_mid_access();
        logic [5:0] exp_f;
        int ck;
        ck = TB_WR + 2;
        bus_if.host_req = 1'b1; bus_if.host_write = 1'b1;
        bus_if.host_address = 10'h0AA; bus_if.host_wr_data = 8'h5A;
        @(negedge clk);
        bus_if.host_req = 1'b0;
        for (int k = 0; k <= ck + TB_RD + 1; k++) begin
            exp_f = {k == 0, k == TB_WR, k == ck, k == ck + TB_RD,
                     (k <= TB_WR) || (k >= ck && k <= ck + TB_RD), k < TB_WR};
            n_checks++;
            if (flags() !== exp_f) begin
                n_bad++; $display("FAIL mid_access_flags k=%0d got=%b want=%b", k, flags(), exp_f);
            end
            if (k == ck + TB_RD) begin
                n_checks++;
                if (bus_if.rd_data !== 8'h5A) begin
                    n_bad++; $display("FAIL mid_access_read got=%h want=5a", bus_if.rd_data);
                end
            end
            if (k == 1) begin
                bus_if.ca_req = 1'b1; bus_if.ca_write = 1'b0; bus_if.ca_address = 10'h0AA;
            end
            if (k == ck) bus_if.ca_req = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp_f;
        bus_if.host_req = 1'b1; bus_if.host_write = 1'b1;
        bus_if.host_address = 10'h123; bus_if.host_wr_data = 8'h77;
        @(negedge clk);
        bus_if.host_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_if.sram_write_enable !== 1'b1) begin
            n_bad++; $display("FAIL rst_mid_pre we got=%b want=1", bus_if.sram_write_enable);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({flags(), bus_if.sram_address, bus_if.sram_write_data, bus_if.rd_data} !== 32'd0) begin
            n_bad++; $display("FAIL rst_mid_async got=%h want=0", {flags(), bus_if.sram_address, bus_if.sram_write_data, bus_if.rd_data});
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (flags() !== 6'b0) begin
                n_bad++; $display("FAIL rst_mid_hold i=%0d got=%b want=000000", i, flags());
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.host_req = 1'b1; bus_if.host_write = 1'b0; bus_if.host_address = 10'h155;
        @(negedge clk);
        bus_if.host_req = 1'b0;
        for (int k = 0; k <= TB_RD + 1; k++) begin
            exp_f = {k == 0, k == TB_RD, 1'b0, 1'b0, k <= TB_RD, 1'b0};
            n_checks++;
            if (flags() !== exp_f) begin
                n_bad++; $display("FAIL rst_mid_after k=%0d got=%b want=%b", k, flags(), exp_f);
            end
            if (k == TB_RD) begin
                n_checks++;
                if (bus_if.rd_data !== 8'hA5) begin
                    n_bad++; $display("FAIL rst_mid_read got=%h want=a5", bus_if.rd_data);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_withdraw();
        int done_at;
        bus_if.host_req = 1'b1; bus_if.host_write = 1'b1;
        bus_if.host_address = 10'h200; bus_if.host_wr_data = 8'hC3;
        @(negedge clk);
        bus_if.host_req = 1'b0;
        done_at = -1;
        for (int k = 0; k <= TB_WR + 1; k++) begin
            if (bus_if.host_done && done_at < 0) done_at = k;
            @(negedge clk);
        end
        n_checks++;
        if (done_at != TB_WR) begin
            n_bad++; $display("FAIL withdraw_done got=%0d want=%0d", done_at, TB_WR);
        end
        n_checks++;
        if (mem[10'h200] !== 8'hC3) begin
            n_bad++; $display("FAIL withdraw_mem got=%h want=c3", mem[10'h200]);
        end
    endtask

    task automatic test_random();
        bit act, m_host, m_write, last_host, h_pend, c_pend, h_wr, c_wr;
        int k, len;
        logic [9:0] e_addr, h_addr, c_addr;
        logic [7:0] e_wdata, e_rd, h_data, c_data;
        logic [5:0] exp_f;
        apply_reset();
        act = 1'b0; m_host = 1'b0; m_write = 1'b0; last_host = 1'b0;
        h_pend = 1'b0; c_pend = 1'b0; h_wr = 1'b0; c_wr = 1'b0;
        k = 0; len = 0;
        e_addr = 10'd0; e_wdata = 8'd0; e_rd = 8'd0;
        h_addr = 10'd0; c_addr = 10'd0; h_data = 8'd0; c_data = 8'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            exp_f = {act && k == 0 && m_host, act && k == len && m_host,
                     act && k == 0 && !m_host, act && k == len && !m_host,
                     act, act && m_write && k < len};
            n_checks++;
            if (flags() !== exp_f) begin
                n_bad++; $display("FAIL rand_flags cyc=%0d got=%b want=%b", cyc, flags(), exp_f);
            end
            n_checks++;
            if ({bus_if.sram_address, bus_if.sram_write_data, bus_if.rd_data} !== {e_addr, e_wdata, e_rd}) begin
                n_bad++; $display("FAIL rand_data cyc=%0d got=%h/%h/%h want=%h/%h/%h", cyc,
                    bus_if.sram_address, bus_if.sram_write_data, bus_if.rd_data, e_addr, e_wdata, e_rd);
            end
            // Requesters drop on their grant, and may ask again at once.
            if (exp_f[5]) h_pend = 1'b0;
            if (exp_f[3]) c_pend = 1'b0;
            if (!h_pend && $urandom_range(0, 2) == 0) begin
                h_pend = 1'b1; h_wr = 1'($urandom_range(0, 1));
                h_addr = 10'($urandom_range(0, 15)); h_data = 8'($urandom);
            end
            if (!c_pend && $urandom_range(0, 2) == 0) begin
                c_pend = 1'b1; c_wr = 1'($urandom_range(0, 1));
                c_addr = 10'($urandom_range(0, 15)); c_data = 8'($urandom);
            end
            // Advance the model across the coming edge.
            if (act) begin
                if (!m_write && k == len - 1) e_rd = mem[e_addr];
                if (k == len) begin
                    act = 1'b0; last_host = m_host;
                end else begin
                    k++;
                end
            end else if (h_pend || c_pend) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                m_host = (h_pend && c_pend) ? !last_host : h_pend;
`else
                m_host = h_pend;
`endif
                m_write = m_host ? h_wr : c_wr;
                e_addr  = m_host ? h_addr : c_addr;
                if (m_write) e_wdata = m_host ? h_data : c_data;
                len = m_write ? TB_WR : TB_RD;
                act = 1'b1; k = 0;
            end
            bus_if.host_req = h_pend; bus_if.host_write = h_wr;
            bus_if.host_address = h_addr; bus_if.host_wr_data = h_data;
            bus_if.ca_req = c_pend; bus_if.ca_write = c_wr;
            bus_if.ca_address = c_addr; bus_if.ca_wr_data = c_data;
            @(negedge clk);
        end
        idle_inputs();
        repeat (TB_WR + 4) @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_bad = 0;
        test_reset();
        test_host_write();
        test_ca_read();
        test_tie();
        test_mid_access();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
